reg_index_encoder: RTL and testbench
====================================

# reg_index_encoder

Registered round-robin encoder: collects a 32-line request mask (one bit per architectural register), holds pending requests, and emits one 5-bit register number at a time over a valid/ready handshake. It is the reverse of the 5-to-32 register decoder: that decoder fans a register number out to one-hot write enables; this block folds one-hot request lines back into register numbers. Write-back and scoreboard logic use it to serialise multi-register events into single register-number transactions.

## Interface
- N, 32: number of request lines / registers.
- W, 5: index width, must equal clog2(N).
- SKIP_ZERO, 1: when 1, request bit 0 is discarded ($r0 is hardwired zero).

- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- set_valid  in  1  qualifies set_mask this cycle.
- set_mask  in  N  request bits to OR into the pending set.
- out_valid  out  1  out_regNum/out_onehot hold a valid index.
- out_ready  in  1  consumer accepts the index when high with out_valid.
- out_regNum  out  W  offered register number.
- out_onehot  out  N  one-hot of out_regNum; all zero when out_valid=0.
- pending  out  N  registered pending set (excludes the index being offered).
- empty  out  1  pending==0 and out_valid==0.

## Operation
- State: pending[N], offer register (out_regNum, out_onehot), last_grant[W], FSM {IDLE, OFFER}.
- pending update each edge: pending <= (pending & ~load_onehot) | (set_valid ? set_mask_eff : 0); set_mask_eff clears bit 0 when SKIP_ZERO=1.
- Pick: round-robin over registered pending, searching from (last_grant+1) mod N upward with wrap; first set bit wins. Search uses pending before this cycle's set_mask.
- IDLE: if pending!=0, load pick into offer register, set last_grant=pick, clear that bit from pending, go OFFER; otherwise stay.
- OFFER: hold out_regNum/out_onehot stable while out_ready=0. On handshake (out_valid & out_ready): if pending!=0 load next pick same edge (stay OFFER); else go IDLE, out_onehot<=0.
- Setting a bit already pending: no effect (merge). Setting the bit currently offered: it re-enters pending and is issued again later.
- out_onehot equals decoder(out_regNum) whenever out_valid=1.

## Timing
- Reset (async, while reset_n=0): pending=0, out_valid=0, out_regNum=0, out_onehot=0, last_grant=N-1 (first search starts at index 0), FSM=IDLE, empty=1.
- Latency: set_mask sampled at edge E -> visible in pending after E -> out_valid=1 after edge E+1 (2 cycles from IDLE).
- Throughput: one index per cycle while out_ready=1 and pending non-empty; no bubble between back-to-back handshakes.
- out_valid never drops without a handshake (except reset).
- Reset asserted mid-transaction: all state clears immediately; the offered index is lost; no partial handshake.
- Wrap: last_grant=N-1 searches from 0; pending holding only last_grant's own bit is still found (full-circle search).

## Structure
- Package reg_index_pkg: N/W defaults, FSM enum {IDLE, OFFER}, function onehot_of(index).
- One sub-module: rr_index_pick (combinational: pending, last_grant -> found, pick index, pick one-hot); the top holds all registers and the FSM.

## Test plan
- Reset: hold reset_n=0 with set_valid=1, mask=0xFFFF_FFFF -> all outputs at reset values, empty=1; release -> still empty (mask not captured during reset).
- Basic: set_mask=0x0000_0090 one cycle, out_ready=1 -> out_regNum 4 then 7 on consecutive cycles, out_onehot 0x10 then 0x80, then out_valid=0, empty=1.
- Backpressure: offer 4 with out_ready=0 for 5 cycles -> out_regNum/out_onehot stable at 4/0x10; ready high -> 7 next cycle.
- Round-robin wrap: after a grant of 30, pending={1,5,31} -> issue order 31, 1, 5.
- Edge cases: SKIP_ZERO=1, set_mask=0x1 -> nothing issued, empty stays 1; set bit 9 on the same edge 9 is handshaked -> 9 is issued again afterwards.
- Reset mid-operation: pending=0xF0, reset_n pulsed low while offering 4 -> out_valid=0, pending=0 immediately; nothing issued after release.

Source files
------------

// File: rtl/reg_index_pkg.sv
// Shared defaults and helpers for the register-index encoder.
package reg_index_pkg;

    localparam int REG_N = 32;
    localparam int REG_W = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } enc_state_t;

    // One-hot expansion of a register number; the same mapping as the 5-to-32 decoder.
    function automatic logic [REG_N-1:0] onehot_of(input logic [REG_W-1:0] index);
        onehot_of        = '0;
        onehot_of[index] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_index_pick.sv
// Round-robin pick over the pending set, starting just above the last grant.
module rr_index_pick
    import reg_index_pkg::*;
#(
    parameter int N = REG_N,
    parameter int W = REG_W
) (
    input  logic [N-1:0] pending,
    input  logic [W-1:0] last_grant,
    output logic         found,
    output logic [W-1:0] pick,
    output logic [N-1:0] pick_onehot
);

    // Walk a full circle so a lone bit at last_grant itself is still found last.
    always_comb begin
        logic [W-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(last_grant) + i) % N);
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        pick_onehot = found ? onehot_of(pick) : '0;
    end

endmodule

// File: rtl/reg_index_encoder.sv
// Folds a 32-line register request mask back into a stream of register
// numbers, one per valid/ready handshake, in round-robin order.
module reg_index_encoder
    import reg_index_pkg::*;
#(
    parameter int N         = REG_N,
    parameter int W         = REG_W,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         set_valid,
    input  logic [N-1:0] set_mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_regNum,
    output logic [N-1:0] out_onehot,
    output logic [N-1:0] pending,
    output logic         empty
);

    // $r0 is hardwired zero, so its request line can be dropped at the input.
    localparam logic [N-1:0] DROP_MASK = SKIP_ZERO ? {{(N-1){1'b0}}, 1'b1} : '0;

    enc_state_t   state;
    logic [W-1:0] last_grant;
    logic         found;
    logic [W-1:0] pick;
    logic [N-1:0] pick_onehot;
    logic         handshake;
    logic         load;
    logic [N-1:0] load_onehot;
    logic [N-1:0] set_mask_eff;

    rr_index_pick #(
        .N(N),
        .W(W)
    ) u_pick (
        .pending    (pending),
        .last_grant (last_grant),
        .found      (found),
        .pick       (pick),
        .pick_onehot(pick_onehot)
    );

    // A new index is loaded from IDLE, or on a handshake when more work is pending.
    always_comb begin
        handshake    = (state == OFFER) && out_ready;
        load         = found && ((state == IDLE) || handshake);
        load_onehot  = load ? pick_onehot : '0;
        set_mask_eff = set_valid ? (set_mask & ~DROP_MASK) : '0;
        out_valid    = (state == OFFER);
        empty        = (pending == '0) && (state != OFFER);
    end

    // Pending set: retire the loaded bit, merge new requests (re-arms the offered bit).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~load_onehot) | set_mask_eff;
        end
    end

    // Offer register and FSM: hold stable under backpressure, reload with no bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            out_regNum <= '0;
            out_onehot <= '0;
            last_grant <= W'(N - 1);
        end else if (load) begin
            state      <= OFFER;
            out_regNum <= pick;
            out_onehot <= pick_onehot;
            last_grant <= pick;
        end else if (handshake) begin
            state      <= IDLE;
            out_onehot <= '0;
        end
    end

endmodule

// File: tb/tb_reg_index_encoder.sv
// Scoreboard bench for reg_index_encoder: expected register numbers are queued
// when requests are driven and checked as each handshake completes.
module tb_reg_index_encoder;

    logic        clock;
    logic        reset_n;
    logic        set_valid;
    logic [31:0] set_mask;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_regNum;
    logic [31:0] out_onehot;
    logic [31:0] pending;
    logic        empty;

    int n_vec;
    int n_err;
    int exp_q[$];

    reg_index_encoder #(
        .N(32),
        .W(5),
        .SKIP_ZERO(1'b1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .set_valid (set_valid),
        .set_mask  (set_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_regNum(out_regNum),
        .out_onehot(out_onehot),
        .pending   (pending),
        .empty     (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every accepted index must be the next one the scoreboard expects.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {27'd0, out_regNum}, 32'hFFFF_FFFF);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("issue_regnum", {27'd0, out_regNum}, e);
                chk("issue_onehot", out_onehot, 32'd1 << e);
            end
        end
    end

    task automatic drive_set(input logic [31:0] mask);
        @(posedge clock); #1;
        set_valid = 1'b1;
        set_mask  = mask;
        @(posedge clock); #1;
        set_valid = 1'b0;
        set_mask  = '0;
    endtask

    task automatic wait_offer();
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (out_valid) break;
        end
        chk("offer_seen", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock); #1;
            if (exp_q.size() == 0 && empty) break;
        end
        chk("drain_queue", exp_q.size(), 32'd0);
        chk("drain_empty", {31'd0, empty}, 32'd1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        set_valid = 1'b1;
        set_mask  = 32'hFFFF_FFFF;
        out_ready = 1'b0;

        // Reset held with requests asserted: nothing may be captured.
        repeat (3) @(negedge clock);
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_regnum", {27'd0, out_regNum}, 32'd0);
        chk("rst_onehot", out_onehot, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_empty",  {31'd0, empty}, 32'd1);
        @(posedge clock); #1;
        reset_n   = 1'b1;
        set_valid = 1'b0;
        set_mask  = '0;
        repeat (3) @(negedge clock);
        chk("post_rst_empty", {31'd0, empty}, 32'd1);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        // Basic: {4,7} with ready high, consecutive issue, two-cycle latency.
        out_ready = 1'b1;
        exp_q.push_back(4);
        exp_q.push_back(7);
        drive_set(32'h0000_0090);
        @(negedge clock);
        chk("basic_pending", pending, 32'h0000_0090);
        chk("basic_lat_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        chk("basic_first",  {27'd0, out_regNum}, 32'd4);
        chk("basic_first_oh", out_onehot, 32'h0000_0010);
        @(negedge clock);
        chk("basic_second", {27'd0, out_regNum}, 32'd7);
        chk("basic_second_oh", out_onehot, 32'h0000_0080);
        @(negedge clock);
        chk("basic_done_valid", {31'd0, out_valid}, 32'd0);
        chk("basic_done_oh", out_onehot, 32'd0);
        chk("basic_done_empty", {31'd0, empty}, 32'd1);

        // Backpressure: offer must hold stable while ready is low.
        out_ready = 1'b0;
        drive_set(32'h0000_0090);
        wait_offer();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_hold_regnum", {27'd0, out_regNum}, 32'd4);
            chk("bp_hold_onehot", out_onehot, 32'h0000_0010);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clock); #1;
        exp_q.push_back(4);
        exp_q.push_back(7);
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("bp_next", {27'd0, out_regNum}, 32'd7);
        wait_drain();

        // Wrap: grant 30, then {1,5,31} must issue 31, 1, 5.
        exp_q.push_back(30);
        drive_set(32'h4000_0000);
        wait_drain();
        exp_q.push_back(31);
        exp_q.push_back(1);
        exp_q.push_back(5);
        drive_set(32'h8000_0022);
        wait_drain();

        // Bit 0 is discarded.
        drive_set(32'h0000_0001);
        repeat (4) @(negedge clock);
        chk("skip0_empty", {31'd0, empty}, 32'd1);
        chk("skip0_pending", pending, 32'd0);
        chk("skip0_valid", {31'd0, out_valid}, 32'd0);

        // Re-setting the offered bit on its handshake edge re-issues it.
        out_ready = 1'b0;
        drive_set(32'h0000_0200);
        wait_offer();
        chk("rearm_offer", {27'd0, out_regNum}, 32'd9);
        @(posedge clock); #1;
        exp_q.push_back(9);
        exp_q.push_back(9);
        out_ready = 1'b1;
        set_valid = 1'b1;
        set_mask  = 32'h0000_0200;
        @(posedge clock); #1;
        set_valid = 1'b0;
        set_mask  = '0;
        wait_drain();

        // Async reset while offering 4 out of 0xF0.
        out_ready = 1'b0;
        drive_set(32'h0000_00F0);
        wait_offer();
        chk("mid_offer", {27'd0, out_regNum}, 32'd4);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_pending", pending, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        @(posedge clock); #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(negedge clock);
        chk("after_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("after_rst_empty", {31'd0, empty}, 32'd1);
        chk("after_rst_queue", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
